// File: rtl/rv32i_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipe: stall/flush generation,
// EX operand forwarding selects and a data-memory wait freeze with sticky timeout.
module rv32i_hazard_ctrl #(
  parameter int REG_INX_WTH = 5,
  parameter int FWD_SEL_WTH = 2,
  parameter int TMO_WTH     = 8,
  parameter int MEM_TMO     = 200
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   id_valid_i,
  input  logic [REG_INX_WTH-1:0] id_rs1_inx_i,
  input  logic [REG_INX_WTH-1:0] id_rs2_inx_i,
  input  logic [REG_INX_WTH-1:0] id_rd_inx_i,
  input  logic                   id_RegW_EN_i,
  input  logic                   id_is_lw_i,
  input  logic                   ex_redirect_i,
  input  logic                   mem_busy_i,
  output logic                   stall_if_o,
  output logic                   stall_id_o,
  output logic                   stall_ex_o,
  output logic                   flush_id_o,
  output logic                   flush_ex_o,
  output logic [FWD_SEL_WTH-1:0] fwd_a_sel_o,
  output logic [FWD_SEL_WTH-1:0] fwd_b_sel_o,
  output logic                   err_o
);

  localparam logic [FWD_SEL_WTH-1:0] FWD_RF  = '0;
  localparam logic [FWD_SEL_WTH-1:0] FWD_EXM = FWD_SEL_WTH'(1);
  localparam logic [FWD_SEL_WTH-1:0] FWD_MWB = FWD_SEL_WTH'(2);
  localparam logic [TMO_WTH-1:0]     TMO_LIM = TMO_WTH'(MEM_TMO);

  typedef enum logic {ST_RUN, ST_MWAIT} state_e;

  state_e             state_q;
  logic [TMO_WTH-1:0] cnt_q;
  logic [TMO_WTH-1:0] cnt_d;
  logic               err_q;

  logic                   ex_v_q, ex_regw_q, ex_lw_q;
  logic [REG_INX_WTH-1:0] ex_rd_q, ex_rs1_q, ex_rs2_q;
  logic                   mem_v_q, mem_regw_q, mem_lw_q;
  logic [REG_INX_WTH-1:0] mem_rd_q;
  logic                   wb_v_q, wb_regw_q;
  logic [REG_INX_WTH-1:0] wb_rd_q;

  logic freeze;
  logic load_use;

  function automatic logic writes(input logic v, input logic regw,
                                  input logic [REG_INX_WTH-1:0] rd,
                                  input logic [REG_INX_WTH-1:0] r);
    return v && regw && (rd == r) && (r != '0);
  endfunction

  function automatic logic [FWD_SEL_WTH-1:0] fwd_sel(input logic [REG_INX_WTH-1:0] r);
    logic [FWD_SEL_WTH-1:0] sel;
    sel = FWD_RF;
    if (ex_v_q) begin
      if (writes(mem_v_q, mem_regw_q, mem_rd_q, r) && !mem_lw_q) sel = FWD_EXM;
      else if (writes(wb_v_q, wb_regw_q, wb_rd_q, r))            sel = FWD_MWB;
    end
    return sel;
  endfunction

  // Busy memory freezes from its very first cycle, in RUN as well as MWAIT.
  assign freeze   = !rst_i && mem_busy_i;
  assign load_use = id_valid_i && ex_lw_q &&
                    (writes(ex_v_q, ex_regw_q, ex_rd_q, id_rs1_inx_i) ||
                     writes(ex_v_q, ex_regw_q, ex_rd_q, id_rs2_inx_i));

  always_comb begin
    stall_if_o  = 1'b0;
    stall_id_o  = 1'b0;
    stall_ex_o  = 1'b0;
    flush_id_o  = 1'b0;
    flush_ex_o  = 1'b0;
    fwd_a_sel_o = FWD_RF;
    fwd_b_sel_o = FWD_RF;
    if (!rst_i) begin
      if (freeze) begin
        stall_if_o = 1'b1;
        stall_id_o = 1'b1;
        stall_ex_o = 1'b1;
      end else if (ex_redirect_i) begin
        flush_id_o = 1'b1;
        flush_ex_o = 1'b1;
      end else if (load_use) begin
        stall_if_o = 1'b1;
        stall_id_o = 1'b1;
        flush_ex_o = 1'b1;
      end
      fwd_a_sel_o = fwd_sel(ex_rs1_q);
      fwd_b_sel_o = fwd_sel(ex_rs2_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_v_q  <= 1'b0;
      mem_v_q <= 1'b0;
      wb_v_q  <= 1'b0;
    end else if (!freeze) begin
      ex_v_q  <= id_valid_i && !flush_ex_o;
      mem_v_q <= ex_v_q;
      wb_v_q  <= mem_v_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!freeze) begin
      ex_rd_q    <= id_rd_inx_i;
      ex_rs1_q   <= id_rs1_inx_i;
      ex_rs2_q   <= id_rs2_inx_i;
      ex_regw_q  <= id_RegW_EN_i;
      ex_lw_q    <= id_is_lw_i;
      mem_rd_q   <= ex_rd_q;
      mem_regw_q <= ex_regw_q;
      mem_lw_q   <= ex_lw_q;
      wb_rd_q    <= mem_rd_q;
      wb_regw_q  <= mem_regw_q;
    end
  end

  // The first busy cycle already counts, so err_o is visible in wait cycle MEM_TMO+1.
  assign cnt_d = (cnt_q == TMO_LIM) ? cnt_q : cnt_q + TMO_WTH'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mem_busy_i) begin
            state_q <= ST_MWAIT;
            cnt_q   <= cnt_d;
            if (cnt_d == TMO_LIM) err_q <= 1'b1;
          end
        end
        ST_MWAIT: begin
          if (!mem_busy_i) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_d == TMO_LIM) err_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
// Bench for rv32i_hazard_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an instruction-level pipeline model.
module tb_rv32i_hazard_ctrl;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst, id_valid, id_regw, id_lw, redirect, busy;
  logic [4:0] rs1, rs2, rd;
  logic       stall_if, stall_id, stall_ex, flush_id, flush_ex, err;
  logic [1:0] fwd_a, fwd_b;

  always #5 clk = ~clk;

  rv32i_hazard_ctrl #(.REG_INX_WTH(5), .FWD_SEL_WTH(2), .TMO_WTH(8), .MEM_TMO(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
    .id_rs1_inx_i(rs1), .id_rs2_inx_i(rs2), .id_rd_inx_i(rd),
    .id_RegW_EN_i(id_regw), .id_is_lw_i(id_lw),
    .ex_redirect_i(redirect), .mem_busy_i(busy),
    .stall_if_o(stall_if), .stall_id_o(stall_id), .stall_ex_o(stall_ex),
    .flush_id_o(flush_id), .flush_ex_o(flush_ex),
    .fwd_a_sel_o(fwd_a), .fwd_b_sel_o(fwd_b), .err_o(err)
  );

  typedef struct {
    bit v;
    bit regw;
    bit lw;
    int rd;
    int rs1;
    int rs2;
  } ins_t;

  // Instructions in EX, MEM, WB (index 0, 1, 2).
  ins_t stg[3];
  int   busy_run;
  bit   m_err;
  bit   m_init;
  bit   e_sif, e_sid, e_sex, e_fid, e_fex;
  int   e_fa, e_fb;
  int   n_vec, n_miss;

  function automatic bit wr(ins_t s, int r);
    return s.v && s.regw && s.rd == r && r != 0;
  endfunction

  function automatic int fwd_of(int r);
    if (!stg[0].v) return 0;
    if (wr(stg[1], r) && !stg[1].lw) return 1;
    if (wr(stg[2], r)) return 2;
    return 0;
  endfunction

  task automatic chk(string nm, logic [7:0] got, logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
    end
  endtask

  task automatic settle();
    bit lu;
    @(negedge clk);
    e_sif = 0; e_sid = 0; e_sex = 0; e_fid = 0; e_fex = 0; e_fa = 0; e_fb = 0;
    if (!rst) begin
      lu = id_valid && stg[0].lw && (wr(stg[0], int'(rs1)) || wr(stg[0], int'(rs2)));
      if (busy) begin
        e_sif = 1; e_sid = 1; e_sex = 1;
      end else if (redirect) begin
        e_fid = 1; e_fex = 1;
      end else if (lu) begin
        e_sif = 1; e_sid = 1; e_fex = 1;
      end
      e_fa = fwd_of(stg[0].rs1);
      e_fb = fwd_of(stg[0].rs2);
    end
    chk("m_stall_if", 8'(stall_if), 8'(e_sif));
    chk("m_stall_id", 8'(stall_id), 8'(e_sid));
    chk("m_stall_ex", 8'(stall_ex), 8'(e_sex));
    chk("m_flush_id", 8'(flush_id), 8'(e_fid));
    chk("m_flush_ex", 8'(flush_ex), 8'(e_fex));
    chk("m_fwd_a",    8'(fwd_a),    8'(e_fa));
    chk("m_fwd_b",    8'(fwd_b),    8'(e_fb));
    if (m_init) chk("m_err", 8'(err), 8'(m_err));
  endtask

  task automatic tick();
    ins_t nw;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 3; i++) stg[i].v = 0;
      busy_run = 0;
      m_err    = 0;
      m_init   = 1;
    end else begin
      if (busy) begin
        busy_run++;
        if (busy_run >= TMO) m_err = 1;
      end else begin
        busy_run = 0;
        nw.v    = id_valid && !e_fex;
        nw.regw = id_regw;
        nw.lw   = id_lw;
        nw.rd   = int'(rd);
        nw.rs1  = int'(rs1);
        nw.rs2  = int'(rs2);
        stg[2] = stg[1];
        stg[1] = stg[0];
        stg[0] = nw;
      end
    end
    #1;
  endtask

  task automatic set_id(bit v, int d, int s1, int s2, bit w, bit l);
    id_valid = v; rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2); id_regw = w; id_lw = l;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  initial begin
    n_vec = 0; n_miss = 0; m_init = 0; m_err = 0; busy_run = 0;
    for (int i = 0; i < 3; i++) stg[i] = '{0, 0, 0, 0, 0, 0};
    rst = 1; busy = 1; redirect = 0;
    set_id(1, 5, 5, 5, 1, 1);

    // Reset with memory busy: everything quiet.
    tick();
    settle();
    chk("rst_stall_if", 8'(stall_if), 8'd0);
    chk("rst_stall_ex", 8'(stall_ex), 8'd0);
    chk("rst_flush_ex", 8'(flush_ex), 8'd0);
    chk("rst_err", 8'(err), 8'd0);
    tick();
    rst = 0; busy = 0;
    set_id(0, 0, 0, 0, 0, 0);
    settle();
    chk("post_rst_stall", 8'(stall_if), 8'd0);
    tick();

    // Load-use: lw x5 then add x6,x5,x1.
    set_id(1, 5, 1, 0, 1, 1);
    cyc();
    set_id(1, 6, 5, 1, 1, 0);
    settle();
    chk("lu_stall_if", 8'(stall_if), 8'd1);
    chk("lu_stall_id", 8'(stall_id), 8'd1);
    chk("lu_flush_ex", 8'(flush_ex), 8'd1);
    tick();
    settle();
    chk("lu_once", 8'(stall_if), 8'd0);
    tick();
    set_id(0, 0, 0, 0, 0, 0);
    settle();
    chk("lu_fwd_a", 8'(fwd_a), 8'd2);
    chk("lu_fwd_b", 8'(fwd_b), 8'd0);
    tick();

    // ALU forward: add x3 then sub x4,x3,x3; again with x0.
    set_id(1, 3, 1, 2, 1, 0);
    cyc();
    set_id(1, 4, 3, 3, 1, 0);
    cyc();
    set_id(0, 0, 0, 0, 0, 0);
    settle();
    chk("alu_fwd_a", 8'(fwd_a), 8'd1);
    chk("alu_fwd_b", 8'(fwd_b), 8'd1);
    tick();
    set_id(1, 0, 1, 2, 1, 0);
    cyc();
    set_id(1, 4, 0, 0, 1, 0);
    cyc();
    set_id(0, 0, 0, 0, 0, 0);
    settle();
    chk("x0_fwd_a", 8'(fwd_a), 8'd0);
    chk("x0_fwd_b", 8'(fwd_b), 8'd0);
    tick();

    // Redirect beats a same-cycle load-use.
    set_id(1, 7, 1, 1, 1, 1);
    cyc();
    set_id(1, 8, 7, 7, 1, 0);
    redirect = 1;
    settle();
    chk("rd_flush_id", 8'(flush_id), 8'd1);
    chk("rd_flush_ex", 8'(flush_ex), 8'd1);
    chk("rd_stall_if", 8'(stall_if), 8'd0);
    tick();
    redirect = 0;
    set_id(0, 0, 0, 0, 0, 0);
    settle();
    chk("rd_single", 8'(flush_id), 8'd0);
    tick();

    // Redirect held across a 3-cycle memory wait.
    redirect = 1; busy = 1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("fz_stall_ex", 8'(stall_ex), 8'd1);
      chk("fz_flush_id", 8'(flush_id), 8'd0);
      tick();
    end
    busy = 0;
    settle();
    chk("fz_rel_flush", 8'({flush_id, flush_ex}), 8'd3);
    chk("fz_rel_stall", 8'(stall_if), 8'd0);
    tick();
    redirect = 0;

    // Timeout after TMO wait cycles, sticky until reset.
    busy = 1;
    for (int k = 1; k <= 10; k++) begin
      settle();
      chk("tmo_err", 8'(err), 8'(k >= 5));
      tick();
    end
    busy = 0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("tmo_sticky", 8'(err), 8'd1);
      tick();
    end
    busy = 1;
    cyc();
    rst = 1;
    tick();
    settle();
    chk("rst_mid_err", 8'(err), 8'd0);
    chk("rst_mid_stall", 8'(stall_if), 8'd0);
    tick();
    rst = 0; busy = 0;
    settle();
    chk("rst_mid_run", 8'(stall_ex), 8'd0);
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(199) == 0);
      busy     = ($urandom_range(99) < 15);
      redirect = ($urandom_range(99) < 10);
      set_id($urandom_range(9) != 0, $urandom_range(7), $urandom_range(7),
             $urandom_range(7), $urandom_range(3) != 0, $urandom_range(2) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
